bmp_writer: RTL and testbench

// - Write-side counterpart of the convolution controller's BMP reader: turns convolved channel results into a 24-bit BMP in data memory.
// - Takes 32-bit accumulator results, one channel per transfer, in B,G,R order per pixel, pixel rows bottom-up.
// - Scales and saturates each result to 8 bits and emits an addressed byte stream toward memory.
// - Emits the 54-byte BMP header (optional), the pixel bytes, and zero padding to a 4-byte row boundary.

---
 rtl/bmp_writer_if.sv | 23 ++
 rtl/bmp_writer.sv | 238 +++++++++++++++++++++++
 tb/tb_bmp_writer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmp_writer_if.sv
// Stream bundle for bmp_writer: signed accumulator results in, addressed bytes out.
//   accum_in/accum_valid/accum_ready : one colour channel per transfer (B,G,R per pixel)
//   byte_out/byte_addr/byte_valid/byte_ready : byte stream toward data memory
// The master modport is the writer; the slave modport is the producer/memory side.
interface bmp_writer_if;
  logic [31:0] accum_in;
  logic        accum_valid;
  logic        accum_ready;
  logic [7:0]  byte_out;
  logic [31:0] byte_addr;
  logic        byte_valid;
  logic        byte_ready;

  modport master (
    input  accum_in, accum_valid, byte_ready,
    output accum_ready, byte_out, byte_addr, byte_valid
  );

  modport slave (
    output accum_in, accum_valid, byte_ready,
    input  accum_ready, byte_out, byte_addr, byte_valid
  );
endinterface

// File: rtl/bmp_writer.sv
// bmp_writer: turns convolved channel results into a 24-bit BMP byte stream.
// Each accepted accumulator value is shifted right by Shift, clamped to 0..255 and written
// as one byte; rows are zero-padded to a 4-byte boundary.
// Optional feature macro BMP_WRITER_HEADER_EN: when defined, a 54-byte BMP header precedes
// the pixel data (pixels start at base + 54); when undefined, pixels start at base.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            one-cycle start pulse, ignored while busy
//   base_addr_i        byte address of file byte 0
//   img_width_i        pixels per row
//   img_height_i       number of rows
//   busy_o             high whenever not idle
//   done_o             one-cycle pulse after the last byte is accepted
//   bus                accumulator input stream and byte output stream
module bmp_writer #(
  parameter int unsigned Shift = 4,
  parameter int unsigned Ppm   = 2835
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [31:0]       base_addr_i,
  input  logic [31:0]       img_width_i,
  input  logic [31:0]       img_height_i,
  output logic              busy_o,
  output logic              done_o,
  bmp_writer_if.master      bus
);

`ifdef BMP_WRITER_HEADER_EN
  typedef enum logic [2:0] {StIdle, StHeader, StPixel, StPad, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StPixel, StPad, StDone} state_e;
`endif

  state_e      state_q;
  logic [31:0] base_q, w_q, h_q, col_q, row_q, off_q;
  logic [1:0]  chan_q, pad_cnt_q, row_pad_q;
  logic [7:0]  byte_out_q;
  logic [31:0] byte_addr_q;
  logic        byte_valid_q, done_q;

  logic        load_en, acc_xfer, emit_en, last_row, empty_in;
  logic [7:0]  emit_byte, pix_byte;
  logic [1:0]  w3_lo, row_pad_in;
  logic signed [31:0] scaled;

  // Output register can take a new byte when empty or being drained this cycle.
  assign load_en  = !byte_valid_q || bus.byte_ready;
  assign acc_xfer = (state_q == StPixel) && load_en && bus.accum_valid;
  assign last_row = (row_q == h_q - 32'd1);
  assign empty_in = (img_width_i == 32'd0) || (img_height_i == 32'd0);

  // (3*W) mod 4 from the low width bits; pad brings the row up to a multiple of 4.
  assign w3_lo      = img_width_i[1:0] + {img_width_i[0], 1'b0};
  assign row_pad_in = 2'd0 - w3_lo;

  assign scaled = $signed(bus.accum_in) >>> Shift;

  always_comb begin
    pix_byte = scaled[7:0];
    if (scaled < 0) begin
      pix_byte = 8'h00;
    end else if (scaled > 32'sd255) begin
      pix_byte = 8'hFF;
    end
  end

`ifdef BMP_WRITER_HEADER_EN
  logic [5:0]  hdr_idx_q, hdr_rel;
  logic [31:0] row_bytes, file_size, hdr_word;
  logic [7:0]  hdr_byte;

  assign row_bytes = (w_q * 32'd3) + {30'd0, row_pad_q};
  assign file_size = 32'd54 + (row_bytes * h_q);
  // Every multi-byte field from offset 2 onwards sits in a 4-byte slot starting at 2 mod 4;
  // the two 16-bit fields (planes=1, bpp=24) share one slot.
  assign hdr_rel   = hdr_idx_q - 6'd2;

  always_comb begin
    hdr_word = 32'd0;
    case (hdr_rel[5:2])
      4'd0:         hdr_word = file_size;
      4'd2:         hdr_word = 32'd54;
      4'd3:         hdr_word = 32'd40;
      4'd4:         hdr_word = w_q;
      4'd5:         hdr_word = h_q;
      4'd6:         hdr_word = 32'h0018_0001;
      4'd8:         hdr_word = file_size - 32'd54;
      4'd9, 4'd10:  hdr_word = Ppm;
      default:      hdr_word = 32'd0;
    endcase
    hdr_byte = hdr_word[7:0];
    case (hdr_rel[1:0])
      2'd1:    hdr_byte = hdr_word[15:8];
      2'd2:    hdr_byte = hdr_word[23:16];
      2'd3:    hdr_byte = hdr_word[31:24];
      default: hdr_byte = hdr_word[7:0];
    endcase
    if (hdr_idx_q == 6'd0) hdr_byte = 8'h42;
    if (hdr_idx_q == 6'd1) hdr_byte = 8'h4D;
  end
`endif

  always_comb begin
    emit_en   = 1'b0;
    emit_byte = 8'h00;
    case (state_q)
`ifdef BMP_WRITER_HEADER_EN
      StHeader: begin
        emit_en   = load_en;
        emit_byte = hdr_byte;
      end
`endif
      StPixel: begin
        emit_en   = acc_xfer;
        emit_byte = pix_byte;
      end
      StPad:   emit_en = load_en;
      default: emit_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      base_q       <= '0;
      w_q          <= '0;
      h_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      off_q        <= '0;
      chan_q       <= '0;
      pad_cnt_q    <= '0;
      row_pad_q    <= '0;
      byte_out_q   <= '0;
      byte_addr_q  <= '0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef BMP_WRITER_HEADER_EN
      hdr_idx_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (byte_valid_q && bus.byte_ready) byte_valid_q <= 1'b0;
      if (emit_en) begin
        byte_out_q   <= emit_byte;
        byte_addr_q  <= base_q + off_q;
        byte_valid_q <= 1'b1;
        off_q        <= off_q + 32'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            base_q    <= base_addr_i;
            w_q       <= img_width_i;
            h_q       <= img_height_i;
            row_pad_q <= row_pad_in;
            col_q     <= '0;
            row_q     <= '0;
            off_q     <= '0;
            chan_q    <= '0;
            pad_cnt_q <= '0;
`ifdef BMP_WRITER_HEADER_EN
            hdr_idx_q <= '0;
            state_q   <= StHeader;
`else
            state_q   <= empty_in ? StDone : StPixel;
`endif
          end
        end
`ifdef BMP_WRITER_HEADER_EN
        StHeader: begin
          if (load_en) begin
            hdr_idx_q <= hdr_idx_q + 6'd1;
            if (hdr_idx_q == 6'd53) begin
              state_q <= ((w_q == 32'd0) || (h_q == 32'd0)) ? StDone : StPixel;
            end
          end
        end
`endif
        StPixel: begin
          if (acc_xfer) begin
            if (chan_q == 2'd2) begin
              chan_q <= '0;
              if (col_q == w_q - 32'd1) begin
                col_q <= '0;
                if (row_pad_q != 2'd0) begin
                  pad_cnt_q <= '0;
                  state_q   <= StPad;
                end else if (last_row) begin
                  state_q <= StDone;
                end else begin
                  row_q <= row_q + 32'd1;
                end
              end else begin
                col_q <= col_q + 32'd1;
              end
            end else begin
              chan_q <= chan_q + 2'd1;
            end
          end
        end
        StPad: begin
          if (load_en) begin
            if (pad_cnt_q == row_pad_q - 2'd1) begin
              if (last_row) begin
                state_q <= StDone;
              end else begin
                row_q   <= row_q + 32'd1;
                state_q <= StPixel;
              end
            end else begin
              pad_cnt_q <= pad_cnt_q + 2'd1;
            end
          end
        end
        StDone: begin
          // Nothing pending, or the final byte drains this cycle.
          if (load_en) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.accum_ready = (state_q == StPixel) && load_en;
  assign bus.byte_out    = byte_out_q;
  assign bus.byte_addr   = byte_addr_q;
  assign bus.byte_valid  = byte_valid_q;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q;

endmodule

// File: tb/tb_bmp_writer.sv
// Directed bench for bmp_writer. Inputs are driven on the falling edge; outputs are sampled
// shortly after the falling edge, so a byte seen valid & ready there is taken at the next rise.
// Works in both builds: HdrOff shifts all pixel offsets when the header is compiled in.
module tb_bmp_writer;

`ifdef BMP_WRITER_HEADER_EN
  localparam int HdrOff = 54;
`else
  localparam int HdrOff = 0;
`endif

  logic        clk, rst_n, start, busy, done;
  logic [31:0] base, w, h;

  bmp_writer_if bus ();

  bmp_writer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .base_addr_i  (base),
    .img_width_i  (w),
    .img_height_i (h),
    .busy_o       (busy),
    .done_o       (done),
    .bus          (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic bp_en = 1'b0;
  logic stall_chk = 1'b0;
  logic acc_rdy_seen = 1'b0;
  logic [31:0] cap_addr[$];
  logic [7:0]  cap_data[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-ready driver: constant 1, or toggling every cycle for backpressure.
  initial begin
    bus.byte_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_en) bus.byte_ready = ~bus.byte_ready;
      else       bus.byte_ready = 1'b1;
    end
  end

  // Monitor: capture accepted bytes, count Done pulses, check stability while stalled.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [31:0] prev_addr;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (stall_chk && prev_stall) begin
        check_eq("stall_valid", {31'd0, bus.byte_valid}, 32'd1);
        check_eq("stall_data", {24'd0, bus.byte_out}, {24'd0, prev_data});
        check_eq("stall_addr", bus.byte_addr, prev_addr);
      end
      prev_stall = bus.byte_valid && !bus.byte_ready;
      prev_data  = bus.byte_out;
      prev_addr  = bus.byte_addr;
      if (bus.byte_valid && bus.byte_ready) begin
        cap_addr.push_back(bus.byte_addr);
        cap_data.push_back(bus.byte_out);
      end
      if (done) done_cnt++;
      if (bus.accum_ready) acc_rdy_seen = 1'b1;
    end
  end

  task automatic start_frame(input logic [31:0] b, input logic [31:0] ww, input logic [31:0] hh);
    @(negedge clk);
    cap_addr.delete();
    cap_data.delete();
    start = 1'b1;
    base  = b;
    w     = ww;
    h     = hh;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_accum(input logic [31:0] v);
    int t;
    t = 0;
    bus.accum_in    = v;
    bus.accum_valid = 1'b1;
    #1;
    while (!bus.accum_ready && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.accum_ready) check_eq("accum_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.accum_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n0;
    int t;
    n0 = done_cnt;
    t  = 0;
    while (done_cnt == n0 && t < 600) begin
      @(negedge clk);
      #3;
      t++;
    end
    repeat (3) @(negedge clk);
    #3;
    check_eq(tag, done_cnt - n0, 32'd1);
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_accum_ready"}, {31'd0, bus.accum_ready}, 32'd0);
    check_eq({tag, "_byte_out"}, {24'd0, bus.byte_out}, 32'd0);
    check_eq({tag, "_byte_addr"}, bus.byte_addr, 32'd0);
    check_eq({tag, "_byte_valid"}, {31'd0, bus.byte_valid}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  logic [7:0]  pad_exp [8]  = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h05, 8'h06, 8'h00};
  logic [31:0] bp_in   [12] = '{32'h0000_07F0, 32'h0000_1234, 32'hFFFF_FF00, 32'h0000_0000,
                                32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80};
  logic [7:0]  bp_exp  [12] = '{8'h7F, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                8'h05, 8'h06, 8'h07, 8'h08};

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    base            = '0;
    w               = '0;
    h               = '0;
    bus.accum_in    = '0;
    bus.accum_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef BMP_WRITER_HEADER_EN
    // Header: W=2, H=2, base 0x1000 -> FS = 70.
    start_frame(32'h1000, 32'd2, 32'd2);
    for (int i = 1; i <= 12; i++) send_accum(32'h10 * i);
    wait_done("hdr_done");
    check_eq("hdr_count", cap_data.size(), 32'd70);
    if (cap_data.size() >= 70) begin
      check_eq("hdr_b0", cap_data[0], 32'h42);
      check_eq("hdr_b1", cap_data[1], 32'h4D);
      check_eq("hdr_fs0", cap_data[2], 32'h46);
      check_eq("hdr_fs1", cap_data[3], 32'h00);
      check_eq("hdr_fs2", cap_data[4], 32'h00);
      check_eq("hdr_fs3", cap_data[5], 32'h00);
      check_eq("hdr_addr0", cap_addr[0], 32'h1000);
      check_eq("hdr_addr_a", cap_addr[10], 32'h100A);
      check_eq("hdr_off", cap_data[10], 32'h36);
      check_eq("hdr_img0", cap_data[34], 32'h10);
      check_eq("hdr_img1", cap_data[35], 32'h00);
      check_eq("hdr_addr_22", cap_addr[34], 32'h1022);
      check_eq("hdr_ppm0", cap_data[38], 32'h13);
      check_eq("hdr_ppm1", cap_data[39], 32'h0B);
      check_eq("hdr_bpp", cap_data[28], 32'd24);
      check_eq("hdr_pix0", cap_data[54], 32'h01);
      check_eq("hdr_pix_addr", cap_addr[54], 32'h1036);
    end
`endif

    // Padding: W=1, H=2 -> one pad byte per row.
    start_frame(32'h400, 32'd1, 32'd2);
    for (int i = 1; i <= 6; i++) send_accum(32'h10 * i);
    wait_done("pad_done");
    check_eq("pad_count", cap_data.size(), HdrOff + 8);
    if (cap_data.size() >= HdrOff + 8) begin
      for (int i = 0; i < 8; i++) begin
        check_eq($sformatf("pad_data%0d", i), cap_data[HdrOff + i], pad_exp[i]);
        check_eq($sformatf("pad_addr%0d", i), cap_addr[HdrOff + i], 32'h400 + HdrOff + i);
      end
    end

    // Saturation under backpressure: W=4, H=1, no padding.
    bp_en     = 1'b1;
    stall_chk = 1'b1;
    start_frame(32'h800, 32'd4, 32'd1);
    for (int i = 0; i < 12; i++) send_accum(bp_in[i]);
    wait_done("bp_done");
    bp_en     = 1'b0;
    stall_chk = 1'b0;
    check_eq("bp_count", cap_data.size(), HdrOff + 12);
    if (cap_data.size() >= HdrOff + 12) begin
      for (int i = 0; i < 12; i++)
        check_eq($sformatf("bp_data%0d", i), cap_data[HdrOff + i], bp_exp[i]);
      for (int i = 0; i < HdrOff + 12; i++)
        check_eq($sformatf("bp_addr%0d", i), cap_addr[i], 32'h800 + i);
    end

    // Reset mid-frame after 5 pixel bytes, then restart; Start while busy is ignored.
    start_frame(32'h2000, 32'd2, 32'd2);
    for (int i = 1; i <= 5; i++) send_accum(32'h10 * i);
    begin
      int t;
      t = 0;
      while (cap_data.size() < HdrOff + 5 && t < 50) begin
        @(negedge clk);
        #3;
        t++;
      end
      check_eq("rst_pre_count", cap_data.size(), HdrOff + 5);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    start_frame(32'h2000, 32'd1, 32'd1);
    send_accum(32'h10);
    check_eq("restart_busy", {31'd0, busy}, 32'd1);
    start = 1'b1;
    base  = 32'h3000;
    w     = 32'd5;
    send_accum(32'h20);
    start = 1'b0;
    send_accum(32'h30);
    wait_done("restart_done");
    check_eq("restart_count", cap_data.size(), HdrOff + 4);
    if (cap_data.size() >= HdrOff + 4) begin
      check_eq("restart_addr0", cap_addr[0], 32'h2000);
      check_eq("restart_pix0", cap_data[HdrOff], 32'h01);
      check_eq("restart_pix2", cap_data[HdrOff + 2], 32'h03);
      check_eq("restart_pad", cap_data[HdrOff + 3], 32'h00);
      check_eq("restart_last_addr", cap_addr[HdrOff + 3], 32'h2000 + HdrOff + 3);
    end

    // Degenerate: W=0, H=3 -> header only (if present), no pixel stream.
    acc_rdy_seen = 1'b0;
    start_frame(32'h5000, 32'd0, 32'd3);
    wait_done("degen_done");
    check_eq("degen_count", cap_data.size(), HdrOff);
    check_eq("degen_no_ready", {31'd0, acc_rdy_seen}, 32'd0);
`ifdef BMP_WRITER_HEADER_EN
    if (cap_data.size() >= 54) begin
      check_eq("degen_fs0", cap_data[2], 32'h36);
      check_eq("degen_fs1", cap_data[3], 32'h00);
      check_eq("degen_img0", cap_data[34], 32'h00);
      check_eq("degen_h", cap_data[22], 32'h03);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
